sseg_scan_mux: RTL and testbench
================================

// Module: sseg_scan_mux
// PURPOSE
//  Time-multiplexed scan driver for an N-digit common-anode/cathode 7-seg display.
//  Sits directly upstream of BCD_to_sseg: selects one BCDnumber_t digit per slot,
//  drives hex into BCD_to_sseg and the matching one-hot anode line.
//  Inserts anodes-off dead time between digits to suppress ghosting.
//  Latches a frame-coherent snapshot of all digits once per scan frame.
// PARAMETERS
//  N_DIGITS       4        number of display digits (2..8); index N_DIGITS-1 = MSD
//  REFRESH_DIV    100000   clk cycles per digit slot (dead + drive); >= DEAD_CYCLES+2
//  DEAD_CYCLES    16       cycles at slot start with all anodes inactive (>= 1)
//  AN_ACTIVE_HIGH 0        1: anode asserted = 1; 0: anode asserted = 0
// PORTS
//  clk         in   1                        system clock
//  reset_n     in   1                        async reset, active low
//  en          in   1                        scan enable; 0 = display dark
//  digits      in   BCDnumber_t[N_DIGITS]    digit values (digito[3:0], dp)
//  hex         out  BCDnumber_t              digit currently selected, to BCD_to_sseg
//  an          out  N_DIGITS                 anode selects, polarity per AN_ACTIVE_HIGH
//  frame_tick  out  1                        1-cycle pulse at start of each frame
// BEHAVIOUR
//  - One clock, clk; reset_n asynchronous active low. All outputs registered.
//  - Reset: state=IDLE, idx=0, slot counter=0, shadow=0, hex={digito=0,dp=0},
//    an=all inactive, frame_tick=0.
//  - FSM: IDLE, DEAD, DRIVE.
//    IDLE: an inactive. en=1 -> DEAD for idx 0 (frame start, see below).
//    DEAD: DEAD_CYCLES cycles, an inactive, hex already = shadow[idx]; -> DRIVE.
//    DRIVE: REFRESH_DIV-DEAD_CYCLES cycles, an[idx] asserted, others inactive.
//      End of slot: idx <= (idx==N_DIGITS-1) ? 0 : idx+1; -> DEAD.
//  - Frame start (every entry to DEAD with idx 0, incl. from IDLE): same edge
//    shadow <= digits, hex <= digits[0], frame_tick <= 1 for one cycle.
//  - digits changes between frame starts are invisible until next frame start.
//  - en=0 in any state: next edge -> IDLE, an inactive, idx=0, counter=0, hex held.
//  - en re-asserted: restarts at frame start; no partial slot resumed.
//  - Frame period = N_DIGITS*REFRESH_DIV cycles; frame_tick spaced exactly so.
//  - Slot counter width = $clog2(REFRESH_DIV); wraps to 0 at REFRESH_DIV-1.
//  - Async reset mid-slot: outputs go to reset values immediately, no glitch pulse.
//  - Illegal parameter combos rejected by elaboration-time $error.
// CONFIGURATION
//  LEADING_ZERO_BLANK_EN defined: during DRIVE, an[idx] held inactive when idx>0
//    and every shadow digit from N_DIGITS-1 down to idx has digito==0 and dp==0.
//    Digit 0 always driven. Slot timing and frame_tick unchanged.
//  Not defined: every digit driven in its DRIVE phase regardless of value.
// TESTING  (N_DIGITS=4, REFRESH_DIV=8, DEAD_CYCLES=2, AN_ACTIVE_HIGH=0)
//  1 reset_n=0 -> an=4'b1111, hex=0/dp0, frame_tick=0; hold en=1 -> no change.
//  2 en=1, digits={4,3,2,1} -> frame_tick pulse; 2 cyc an=1111 hex=1, 6 cyc an=1110;
//    then hex=2 an=1111x2, 1101x6; ...; 1000 pattern for 4? no: an=0111 for hex=4;
//    next frame_tick exactly 32 cycles after first.
//  3 change digits to {9,9,9,9} during slot 1 -> slots 1..3 still show 2,3,4;
//    9s appear from next frame start.
//  4 drop en at DRIVE cycle 3 of slot 2 -> next edge an=1111, IDLE; re-raise
//    -> frame_tick, restart at idx 0.
//  5 macro defined, digits={0,0,0,7} -> only an[0] asserts; {0,5,0,7} -> an[0..2]
//    assert, an[3] never; macro undefined -> all four assert.
//  6 AN_ACTIVE_HIGH=1, scenario 2 -> an inverted (0000 dead, 0001 drive slot 0).

Source files
------------

// File: rtl/sseg_scan_mux.sv
// Multiplexed 7-seg scan driver with dead time and per-frame digit snapshot.
// Optional LEADING_ZERO_BLANK_EN blanks leading all-zero digits.
package sseg_pkg;
    typedef struct packed {
        logic [3:0] digito;
        logic       dp;
    } BCDnumber_t;
endpackage

module sseg_scan_mux
    import sseg_pkg::*;
#(
    parameter int N_DIGITS       = 4,
    parameter int REFRESH_DIV    = 100000,
    parameter int DEAD_CYCLES    = 16,
    parameter bit AN_ACTIVE_HIGH = 1'b0
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic                         en,
    input  BCDnumber_t [N_DIGITS-1:0]    digits,
    output BCDnumber_t                   hex,
    output logic       [N_DIGITS-1:0]    an,
    output logic                         frame_tick
);

    localparam int CW = $clog2(REFRESH_DIV);
    localparam int IW = $clog2(N_DIGITS);
    localparam logic [CW-1:0] DEAD_LAST = CW'(DEAD_CYCLES - 1);
    localparam logic [CW-1:0] SLOT_LAST = CW'(REFRESH_DIV - 1);
    localparam logic [IW-1:0] IDX_LAST  = IW'(N_DIGITS - 1);
    localparam logic [N_DIGITS-1:0] AN_OFF =
        AN_ACTIVE_HIGH ? {N_DIGITS{1'b0}} : {N_DIGITS{1'b1}};

    if (N_DIGITS < 2 || N_DIGITS > 8) begin : g_bad_n
        $error("sseg_scan_mux: N_DIGITS must be 2..8");
    end
    if (DEAD_CYCLES < 1) begin : g_bad_dead
        $error("sseg_scan_mux: DEAD_CYCLES must be >= 1");
    end
    if (REFRESH_DIV < DEAD_CYCLES + 2) begin : g_bad_div
        $error("sseg_scan_mux: REFRESH_DIV must be >= DEAD_CYCLES+2");
    end

    typedef enum logic [1:0] {IDLE, DEAD, DRIVE} state_t;

    state_t                     state_q, state_d;
    logic [IW-1:0]              idx_q, idx_d;
    logic [CW-1:0]              cnt_q, cnt_d;
    BCDnumber_t [N_DIGITS-1:0]  shadow_q, shadow_d;
    BCDnumber_t                 hex_d;
    logic [N_DIGITS-1:0]        an_d, sel, drive_sel;
    logic                       tick_d, frame_start, blank;

`ifdef LEADING_ZERO_BLANK_EN
    // Blank when no digit at or above idx carries anything visible.
    logic nz;
    always_comb begin
        nz = 1'b0;
        for (int i = 0; i < N_DIGITS; i++) begin
            if (i >= int'(idx_q) &&
                (shadow_q[i].digito != 4'd0 || shadow_q[i].dp))
                nz = 1'b1;
        end
        blank = (idx_q != '0) && !nz;
    end
`else
    assign blank = 1'b0;
`endif

    always_comb begin
        drive_sel        = '0;
        drive_sel[idx_q] = !blank;
    end

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        cnt_d       = cnt_q;
        shadow_d    = shadow_q;
        hex_d       = hex;
        sel         = '0;
        tick_d      = 1'b0;
        frame_start = 1'b0;
        if (!en) begin
            state_d = IDLE;
            idx_d   = '0;
            cnt_d   = '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    state_d     = DEAD;
                    idx_d       = '0;
                    cnt_d       = '0;
                    frame_start = 1'b1;
                end
                DEAD: begin
                    cnt_d = cnt_q + CW'(1);
                    if (cnt_q == DEAD_LAST) begin
                        state_d = DRIVE;
                        sel     = drive_sel;
                    end
                end
                DRIVE: begin
                    if (cnt_q == SLOT_LAST) begin
                        state_d = DEAD;
                        cnt_d   = '0;
                        if (idx_q == IDX_LAST) begin
                            idx_d       = '0;
                            frame_start = 1'b1;
                        end else begin
                            idx_d = idx_q + IW'(1);
                            hex_d = shadow_q[idx_d];
                        end
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                        sel   = drive_sel;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
        if (frame_start) begin
            shadow_d = digits;
            hex_d    = digits[0];
            tick_d   = 1'b1;
        end
        an_d = AN_ACTIVE_HIGH ? sel : ~sel;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            idx_q      <= '0;
            cnt_q      <= '0;
            shadow_q   <= '0;
            hex        <= '0;
            an         <= AN_OFF;
            frame_tick <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            cnt_q      <= cnt_d;
            shadow_q   <= shadow_d;
            hex        <= hex_d;
            an         <= an_d;
            frame_tick <= tick_d;
        end
    end

endmodule

// File: tb/tb_sseg_scan_mux.sv
// Scoreboard bench for sseg_scan_mux: timeline reference model vs DUT outputs.
module tb_sseg_scan_mux;
    import sseg_pkg::*;

    localparam int N   = 4;
    localparam int RD  = 8;
    localparam int DC  = 2;
    localparam bit AHI = 1'b0;
    localparam logic [N-1:0] AN_OFF = AHI ? 4'h0 : 4'hF;

    typedef struct {
        logic [N-1:0] an;
        BCDnumber_t   hex;
        logic         tick;
    } exp_t;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic en = 1'b0;
    BCDnumber_t [N-1:0] digits = '0;
    BCDnumber_t hex;
    logic [N-1:0] an;
    logic frame_tick;

    int checks = 0;
    int errors = 0;
    exp_t expq[$];

    int run = 0;
    BCDnumber_t [N-1:0] m_shadow = '0;
    BCDnumber_t m_hex = '0;

    sseg_scan_mux #(
        .N_DIGITS(N), .REFRESH_DIV(RD),
        .DEAD_CYCLES(DC), .AN_ACTIVE_HIGH(AHI)
    ) dut (
        .clk(clk), .reset_n(reset_n), .en(en), .digits(digits),
        .hex(hex), .an(an), .frame_tick(frame_tick)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input exp_t x);
        checks++;
        if (an !== x.an || hex !== x.hex || frame_tick !== x.tick) begin
            errors++;
            $display("FAIL %s t=%0t: got an=%b hex=%0d.%b tick=%b, want an=%b hex=%0d.%b tick=%b",
                nm, $time, an, hex.digito, hex.dp, frame_tick,
                x.an, x.hex.digito, x.hex.dp, x.tick);
        end
    endtask

    // Highest digit with visible content, -1 when the frame is all zero.
    function automatic int top_nonzero(input BCDnumber_t [N-1:0] s);
        int h = -1;
        for (int i = 0; i < N; i++)
            if (s[i].digito != 0 || s[i].dp) h = i;
        return h;
    endfunction

    task automatic model_step(input logic rst, input logic en_v,
                              input BCDnumber_t [N-1:0] d);
        exp_t x;
        int pos, slot, ph;
        bit lit;
        logic [N-1:0] s;
        x.an = AN_OFF;
        x.tick = 1'b0;
        if (rst) begin
            run = 0;
            m_shadow = '0;
            m_hex = '0;
        end else if (!en_v) begin
            run = 0;
        end else begin
            pos  = run % (N * RD);
            slot = pos / RD;
            ph   = pos % RD;
            run++;
            if (pos == 0) m_shadow = d;
            m_hex  = m_shadow[slot];
            x.tick = (pos == 0);
            lit = (ph >= DC);
`ifdef LEADING_ZERO_BLANK_EN
            if (slot > 0 && slot > top_nonzero(m_shadow)) lit = 0;
`endif
            s = lit ? (N'(1) << slot) : '0;
            x.an = AHI ? s : ~s;
        end
        x.hex = m_hex;
        expq.push_back(x);
    endtask

    task automatic cycle(input logic en_v, input BCDnumber_t [N-1:0] d);
        en = en_v;
        digits = d;
        @(posedge clk);
        model_step(!reset_n, en_v, d);
        #2;
    endtask

    function automatic BCDnumber_t [N-1:0] rand_digits();
        BCDnumber_t [N-1:0] d;
        for (int i = 0; i < N; i++) begin
            if ($urandom_range(0, 1) == 0) d[i] = '0;
            else begin
                d[i].digito = 4'($urandom_range(0, 9));
                d[i].dp = 1'($urandom_range(0, 1));
            end
        end
        return d;
    endfunction

    function automatic BCDnumber_t [N-1:0] mk(input int a3, a2, a1, a0);
        BCDnumber_t [N-1:0] d;
        d[3] = '{4'(a3), 1'b0};
        d[2] = '{4'(a2), 1'b0};
        d[1] = '{4'(a1), 1'b0};
        d[0] = '{4'(a0), 1'b0};
        return d;
    endfunction

    initial begin : monitor
        exp_t x;
        forever begin
            @(posedge clk);
            #1;
            if (expq.size() > 0) begin
                x = expq.pop_front();
                chk("scan", x);
            end
        end
    end

    initial begin : stim
        BCDnumber_t [N-1:0] d;
        exp_t r;
        int len;
        #2;
        d = mk(4, 3, 2, 1);
        repeat (3) cycle(1'b1, d);
        reset_n = 1'b1;
        repeat (70) cycle(1'b1, d);
        repeat (200) begin
            if ($urandom_range(0, 5) == 0) d = rand_digits();
            cycle(1'b1, d);
        end
        repeat (20) begin
            len = $urandom_range(1, 80);
            repeat (len) begin
                if ($urandom_range(0, 15) == 0) d = rand_digits();
                cycle(1'b1, d);
            end
            repeat ($urandom_range(1, 5)) cycle(1'b0, d);
        end
        d = mk(0, 0, 0, 7);
        repeat (40) cycle(1'b1, d);
        cycle(1'b0, d);
        d = mk(0, 5, 0, 7);
        repeat (40) cycle(1'b1, d);
        cycle(1'b0, d);
        d = mk(0, 0, 0, 0);
        repeat (40) cycle(1'b1, d);
        cycle(1'b0, d);
        d = mk(9, 0, 0, 0);
        repeat (40) cycle(1'b1, d);
        cycle(1'b0, d);
        repeat (5) cycle(1'b1, rand_digits());
        #2;
        reset_n = 1'b0;
        #1;
        r.an = AN_OFF;
        r.hex = '0;
        r.tick = 1'b0;
        chk("async_reset", r);
        repeat (2) cycle(1'b1, d);
        reset_n = 1'b1;
        repeat (40) cycle(1'b1, rand_digits());
        for (int k = 0; k < 10 && expq.size() > 0; k++) @(negedge clk);
        if (expq.size() > 0) begin
            checks++;
            errors++;
            $display("FAIL drain: got %0d pending, want 0", expq.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
